// File: rtl/match_controller.sv
// Two-bot match sequencer: conditions both goal sensors, arbitrates simultaneous
// hits, keeps score and map state, and declares the winner.
module match_controller #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int COUNTDOWN_CYCLES = 16,
  parameter int HOLD_CYCLES      = 8,
  parameter int WIN_SCORE        = 5,
  parameter int SCORE_W          = 4,
  parameter int MAPS             = 4,
  localparam int MAP_W           = (MAPS > 1) ? $clog2(MAPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sensor1,
  input  logic               sensor2,
  output logic [SCORE_W-1:0] botscore1,
  output logic [SCORE_W-1:0] botscore2,
  output logic               score,
  output logic               score_bot,
  output logic [MAP_W-1:0]   map_sel,
  output logic               map_change,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         winner
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (COUNTDOWN_CYCLES > HOLD_CYCLES) ? COUNTDOWN_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0]      DB_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]      DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]      CD_LAST   = TW'(COUNTDOWN_CYCLES - 1);
  localparam logic [TW-1:0]      HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [MAP_W-1:0]   MAP_LAST  = MAP_W'(MAPS - 1);

  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, HOLD, MAP_CHANGE, GAME_OVER} state_t;

  state_t st, nxt;

  logic [1:0]         sens;
  logic [1:0][1:0]    sync;
  logic [1:0][CW-1:0] dcnt;
  logic [1:0]         lvl, lvl_q, ev;

  logic [TW-1:0] tmr;
  logic          tie_ptr;
  logic          award, award_bot, tie_flip, map_adv, declare, new_match, won;

  assign sens = {sensor2, sensor1};

  // Debounced level only rises after an unbroken run of synchronized-high samples;
  // the event is its rising edge, so a held sensor yields exactly one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      dcnt  <= '0;
      lvl   <= '0;
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][0], sens[i]};
        if (!sync[i][1]) begin
          dcnt[i] <= '0;
          lvl[i]  <= 1'b0;
        end else if (dcnt[i] != DB_MAX) begin
          dcnt[i] <= dcnt[i] + CW'(1);
          if (dcnt[i] == DB_LAST) lvl[i] <= 1'b1;
        end
      end
    end
  end

  assign ev  = lvl & ~lvl_q;
  assign won = score_bot ? (botscore2 == WIN) : (botscore1 == WIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      tmr <= '0;
    end else begin
      st  <= nxt;
      tmr <= (nxt != st) ? '0 : tmr + TW'(1);
    end
  end

  always_comb begin
    nxt       = st;
    award     = 1'b0;
    award_bot = 1'b0;
    tie_flip  = 1'b0;
    map_adv   = 1'b0;
    declare   = 1'b0;
    new_match = 1'b0;
    case (st)
      IDLE:      if (start) nxt = COUNTDOWN;
      COUNTDOWN: if (tmr == CD_LAST) nxt = PLAY;
      PLAY: begin
        if (|ev) begin
          award = 1'b1;
          nxt   = HOLD;
          // Ties go to whoever lost the previous tie; the losing hit is dropped.
          if (&ev) begin
            award_bot = tie_ptr;
            tie_flip  = 1'b1;
          end else begin
            award_bot = ev[1];
          end
        end
      end
      HOLD: begin
        if (tmr == HOLD_LAST) begin
          if (won) begin
            nxt     = GAME_OVER;
            declare = 1'b1;
          end else begin
            nxt     = MAP_CHANGE;
            map_adv = 1'b1;
          end
        end
      end
      MAP_CHANGE: nxt = PLAY;
      GAME_OVER: begin
        if (start) begin
          nxt       = COUNTDOWN;
          new_match = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      botscore1  <= '0;
      botscore2  <= '0;
      score      <= 1'b0;
      score_bot  <= 1'b0;
      map_sel    <= '0;
      map_change <= 1'b0;
      winner     <= 2'b00;
      tie_ptr    <= 1'b0;
    end else begin
      score      <= award;
      map_change <= map_adv;
      if (tie_flip) tie_ptr <= ~tie_ptr;
      if (award) begin
        score_bot <= award_bot;
        if (!award_bot && botscore1 < WIN) botscore1 <= botscore1 + SCORE_W'(1);
        if (award_bot && botscore2 < WIN)  botscore2 <= botscore2 + SCORE_W'(1);
      end
      if (map_adv) map_sel <= (map_sel == MAP_LAST) ? '0 : map_sel + MAP_W'(1);
      if (declare) winner <= score_bot ? 2'b10 : 2'b01;
      if (new_match) begin
        botscore1 <= '0;
        botscore2 <= '0;
        map_sel   <= '0;
        winner    <= 2'b00;
        score_bot <= 1'b0;
      end
    end
  end

  assign playing   = (st == PLAY);
  assign game_over = (st == GAME_OVER);

endmodule
